// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter
//
// Shares the single VGA pixel-write port among four drawing engines
// (rocket, alien fleet, bullets, score/title overlay). An engine that wins
// arbitration owns the port for a whole burst. During that burst its pixel
// stream is registered onto the adapter-facing bus. Winners are chosen
// round-robin. A hold watchdog reclaims the port from an engine that never
// finishes its burst.
//
// Parameters:
//   NREQ      number of requesters (the logic is written for exactly 4)
//   MAX_HOLD  maximum number of cycles a grant may be held
//   HOLD_W    width of the hold counter, 2^HOLD_W > MAX_HOLD
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   req          per-requester port request (level)
//   done         per-requester burst-complete pulse
//   x_in         packed 8-bit x, slice i belongs to requester i
//   y_in         packed 7-bit y, slice i belongs to requester i
//   colour_in    packed 3-bit colour, slice i belongs to requester i
//   plot_in      per-requester pixel-valid
//   grant        one-hot ownership, or all zero
//   xout         registered pixel x to the VGA adapter
//   yout         registered pixel y to the VGA adapter
//   colourOut    registered pixel colour to the VGA adapter
//   plot         registered pixel write enable to the VGA adapter
//   busy         high while a burst is owned or being released
//   timeout_err  one-cycle pulse when the watchdog revokes a grant

module vga_draw_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 19200,
  parameter int HOLD_W   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   done,
  input  logic [8*NREQ-1:0] x_in,
  input  logic [7*NREQ-1:0] y_in,
  input  logic [3*NREQ-1:0] colour_in,
  input  logic [NREQ-1:0]   plot_in,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        xout,
  output logic [6:0]        yout,
  output logic [2:0]        colourOut,
  output logic              plot,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [1:0]        ptr;
  logic [1:0]        ptr_next;
  logic [1:0]        owner;
  logic [1:0]        owner_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic [NREQ-1:0]   grant_next;
  logic [7:0]        x_next;
  logic [6:0]        y_next;
  logic [2:0]        colour_next;
  logic              plot_next;
  logic              timeout_next;

  logic [7:0]        x_arr [NREQ];
  logic [6:0]        y_arr [NREQ];
  logic [2:0]        c_arr [NREQ];

  logic              win_found;
  logic [1:0]        win_idx;
  logic [1:0]        cand;

  // Unpack the per-requester pixel buses so the owner can be selected by index.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      x_arr[i] = x_in[8*i +: 8];
      y_arr[i] = y_in[7*i +: 7];
      c_arr[i] = colour_in[3*i +: 3];
    end
  end

  // Round-robin pick: scan ptr+1, ptr+2, ... with 2-bit wraparound, so the
  // last scanned slot is ptr itself (the previous owner gets lowest priority).
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    cand      = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // All outputs are registered; this block computes their next values.
  // plot defaults to 0 so that it is only high for a cycle following an
  // owner pixel. The pixel sampled on the exit edge of OWN is still
  // forwarded. xout/yout/colourOut hold their values outside OWN.
  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    owner_next   = owner;
    hold_next    = hold_cnt;
    grant_next   = grant;
    x_next       = xout;
    y_next       = yout;
    colour_next  = colourOut;
    plot_next    = 1'b0;
    timeout_next = 1'b0;

    case (state)
      IDLE: begin
        grant_next = '0;
        if (win_found) begin
          state_next = OWN;
          owner_next = win_idx;
          grant_next = NREQ'(1) << win_idx;
          hold_next  = '0;
        end
      end

      OWN: begin
        x_next      = x_arr[owner];
        y_next      = y_arr[owner];
        colour_next = c_arr[owner];
        plot_next   = plot_in[owner];
        hold_next   = hold_cnt + HOLD_W'(1);
        // A real completion (done or withdrawal) takes precedence over the
        // watchdog, so a burst that finishes exactly on time is not flagged.
        if (done[owner] || !req[owner]) begin
          state_next = RELEASE;
          grant_next = '0;
        end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
          state_next   = RELEASE;
          grant_next   = '0;
          timeout_next = 1'b1;
        end
      end

      RELEASE: begin
        grant_next = '0;
        ptr_next   = owner;
        hold_next  = '0;
        state_next = IDLE;
      end

      default: begin
        grant_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers. Reset is asynchronous, so grant and plot
  // drop the moment reset asserts, even in the middle of a burst.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= 2'd3;
      owner       <= 2'd0;
      hold_cnt    <= '0;
      grant       <= '0;
      xout        <= '0;
      yout        <= '0;
      colourOut   <= '0;
      plot        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      owner       <= owner_next;
      hold_cnt    <= hold_next;
      grant       <= grant_next;
      xout        <= x_next;
      yout        <= y_next;
      colourOut   <= colour_next;
      plot        <= plot_next;
      timeout_err <= timeout_next;
    end
  end

  assign busy = (state != IDLE);

endmodule
